// File: rtl/rfphoenix_vecmem_seq_if.sv
// rfphoenix_vecmem_seq_if: bundles the command, memory-request and
// memory-response signals of the vector gather/scatter sequencer.
// The slave modport is the sequencer's view; master is the view of
// whatever drives it (issue logic plus memory side).
interface rfphoenix_vecmem_seq_if #(
    parameter int NLANES = 16
);
    // command side
    logic                   start_i;
    logic                   ready_o;
    logic                   store_i;
    logic [3:0]             rid_i;
    logic [31:0]            base_i;
    logic [32*NLANES-1:0]   idx_i;
    logic [32*NLANES-1:0]   dat_i;
    logic [NLANES-1:0]      mask_i;
    logic                   abort_i;
    logic                   done_o;
    logic [32*NLANES-1:0]   res_o;

    // element request stream towards memory
    logic                   req_wr_o;
    logic                   req_full_i;
    logic                   req_store_o;
    logic [31:0]            req_adr_o;
    logic [31:0]            req_dat_o;
    logic [3:0]             req_rid_o;
    logic [3:0]             req_step_o;

    // element responses from memory
    logic                   resp_v_i;
    logic [3:0]             resp_rid_i;
    logic [3:0]             resp_step_i;
    logic [31:0]            resp_dat_i;

    modport slave (
        input  start_i, store_i, rid_i, base_i, idx_i, dat_i, mask_i, abort_i,
        output ready_o, done_o, res_o,
        output req_wr_o, req_store_o, req_adr_o, req_dat_o, req_rid_o, req_step_o,
        input  req_full_i,
        input  resp_v_i, resp_rid_i, resp_step_i, resp_dat_i
    );

    modport master (
        output start_i, store_i, rid_i, base_i, idx_i, dat_i, mask_i, abort_i,
        input  ready_o, done_o, res_o,
        input  req_wr_o, req_store_o, req_adr_o, req_dat_o, req_rid_o, req_step_o,
        output req_full_i,
        output resp_v_i, resp_rid_i, resp_step_i, resp_dat_i
    );
endinterface

// File: rtl/rfphoenix_vecmem_seq.sv
// rfphoenix_vecmem_seq: walks the lanes of a vector gather/scatter,
// issuing one element request per cycle (bounded by MAXOUT outstanding
// and memory backpressure) and collecting load responses into res_o.
// Optional feature macro: RFPHOENIX_VECMEM_MASKSKIP_EN -- when defined,
// masked-off lanes are skipped instead of issued.
module rfphoenix_vecmem_seq #(
    parameter int NLANES = 16,
    parameter int MAXOUT = 4
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    rfphoenix_vecmem_seq_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    localparam logic [3:0] MAXOUT_C = 4'(MAXOUT);
    localparam logic [3:0] LAST_C   = 4'(NLANES - 1);

    state_t state_q, state_d;

    // operation captured at accept
    logic                    store_q;
    logic [3:0]              rid_q;
    logic [31:0]             base_q;
    logic [NLANES-1:0][31:0] idx_q;
    logic [NLANES-1:0][31:0] dat_q;
    logic [NLANES-1:0][31:0] res_q;
`ifdef RFPHOENIX_VECMEM_MASKSKIP_EN
    logic [NLANES-1:0]       mask_q;
`endif

    logic [3:0] step_q;   // next lane to consider
    logic [3:0] out_q;    // requests issued but not yet answered

    logic [3:0] cur;      // lane issued this cycle
    logic       cur_vld;  // some lane is still left to issue
    logic       cur_last; // cur is the final lane of this operation
    logic       accept;
    logic       issue;
    logic       resp_acc;

`ifdef RFPHOENIX_VECMEM_MASKSKIP_EN
    // Pick the lowest enabled lane at or above step, and note whether any enabled lane lies beyond it.
    always_comb begin
        cur      = '0;
        cur_vld  = 1'b0;
        cur_last = 1'b1;
        for (int n = NLANES - 1; n >= 0; n--) begin
            if (mask_q[n] && (n >= int'(step_q))) begin
                cur     = 4'(n);
                cur_vld = 1'b1;
            end
        end
        for (int n = 0; n < NLANES; n++) begin
            if (mask_q[n] && (n > int'(cur))) cur_last = 1'b0;
        end
    end
`else
    // Every lane issues in order; masking is resolved later at commit.
    always_comb begin
        cur      = step_q;
        cur_vld  = 1'b1;
        cur_last = (step_q == LAST_C);
    end
`endif

    assign accept = (state_q == S_IDLE) && bus.start_i;

    // Abort suppresses the request in the cycle it is raised.
    assign issue = (state_q == S_ISSUE) && cur_vld && !bus.req_full_i &&
                   (out_q < MAXOUT_C) && !bus.abort_i;

    // A response with nothing outstanding is only legal when it answers
    // the request going out in the very same cycle (zero-latency memory).
    assign resp_acc = bus.resp_v_i && !bus.abort_i &&
                      ((state_q == S_ISSUE) || (state_q == S_DRAIN)) &&
                      (bus.resp_rid_i == rid_q) &&
                      ((out_q != 4'd0) || issue);

    // Request outputs are only non-zero while a request is actually strobed.
    assign bus.req_wr_o    = issue;
    assign bus.req_store_o = issue & store_q;
    assign bus.req_adr_o   = issue ? (base_q + idx_q[cur]) : 32'd0;
    assign bus.req_dat_o   = issue ? dat_q[cur] : 32'd0;
    assign bus.req_rid_o   = issue ? rid_q : 4'd0;
    assign bus.req_step_o  = issue ? cur : 4'd0;
    assign bus.res_o       = res_q;

    // State register; reset drops any operation in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state and status outputs.
    always_comb begin
        state_d     = state_q;
        bus.ready_o = 1'b0;
        bus.done_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.ready_o = 1'b1;
                if (bus.start_i) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (bus.abort_i)                     state_d = S_IDLE;
                else if (!cur_vld)                   state_d = S_DRAIN;
                else if (issue && cur_last)          state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.abort_i)                     state_d = S_IDLE;
                else if (out_q == 4'd0)              state_d = S_DONE;
            end
            S_DONE: begin
                bus.done_o = !bus.abort_i;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operation capture, lane stepping, outstanding count and result collection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            store_q <= 1'b0;
            rid_q   <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            dat_q   <= '0;
            res_q   <= '0;
            step_q  <= '0;
            out_q   <= '0;
`ifdef RFPHOENIX_VECMEM_MASKSKIP_EN
            mask_q  <= '0;
`endif
        end else if (accept) begin
            store_q <= bus.store_i;
            rid_q   <= bus.rid_i;
            base_q  <= bus.base_i;
            idx_q   <= bus.idx_i;
            dat_q   <= bus.dat_i;
            res_q   <= '0;
            step_q  <= '0;
            out_q   <= '0;
`ifdef RFPHOENIX_VECMEM_MASKSKIP_EN
            mask_q  <= bus.mask_i;
`endif
        end else begin
            // the final lane leaves step parked rather than wrapping to 0
            if (issue) step_q <= cur_last ? cur : cur + 4'd1;

            if (issue && !resp_acc)      out_q <= out_q + 4'd1;
            else if (!issue && resp_acc) out_q <= out_q - 4'd1;

            if (resp_acc && !store_q) res_q[bus.resp_step_i] <= bus.resp_dat_i;
        end
    end
endmodule
